// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: majority-samples rx_in per bit, assembles the byte,
// strobes the downstream stop checker and reports data/parity/stop/start outcomes.
module uart_rx_frame_ctrl (
  input  logic       clk_based_on_prescale,
  input  logic       asy_reset,
  input  logic       rx_in,
  input  logic [5:0] prescale,
  input  logic       par_en,
  input  logic       par_typ,
  input  logic       stop_error,
  output logic       sampled_data,
  output logic       stop_check_enable,
  output logic [7:0] p_data,
  output logic       data_valid,
  output logic       par_error,
  output logic       stp_error,
  output logic       strt_glitch
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t      state_r;
  logic [5:0]  edge_cnt_r;
  logic [2:0]  bit_cnt_r;
  logic [5:0]  presc_r;
  logic        par_en_r;
  logic        par_typ_r;
  logic [2:0]  smp_r;
  logic [7:0]  shift_r;
  logic        par_err_r;

  logic [5:0]  last_edge_s;
  logic [5:0]  mid_edge_s;
  logic [5:0]  first_edge_s;
  logic [5:0]  third_edge_s;
  logic [5:0]  vote_edge_s;
  logic        bit_end_s;
  logic        in_frame_s;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  function automatic logic exp_parity(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // Sample points and bit-end decode derived from the latched prescale.
  always_comb begin
    last_edge_s  = presc_r - 6'd1;
    mid_edge_s   = {1'b0, presc_r[5:1]};
    first_edge_s = mid_edge_s - 6'd1;
    third_edge_s = mid_edge_s + 6'd1;
    vote_edge_s  = mid_edge_s + 6'd2;
    bit_end_s    = (edge_cnt_r == last_edge_s);
    in_frame_s   = (state_r == START) || (state_r == DATA) ||
                   (state_r == PARITY) || (state_r == STOP);
  end

  // Frame FSM with oversampling counters, majority vote and registered outputs.
  always_ff @(posedge clk_based_on_prescale or posedge asy_reset) begin
    if (asy_reset) begin
      state_r           <= IDLE;
      edge_cnt_r        <= 6'd0;
      bit_cnt_r         <= 3'd0;
      presc_r           <= 6'd0;
      par_en_r          <= 1'b0;
      par_typ_r         <= 1'b0;
      smp_r             <= 3'd0;
      shift_r           <= 8'd0;
      par_err_r         <= 1'b0;
      sampled_data      <= 1'b0;
      stop_check_enable <= 1'b0;
      p_data            <= 8'd0;
      data_valid        <= 1'b0;
      par_error         <= 1'b0;
      stp_error         <= 1'b0;
      strt_glitch       <= 1'b0;
    end else begin
      stop_check_enable <= 1'b0;
      data_valid        <= 1'b0;
      par_error         <= 1'b0;
      stp_error         <= 1'b0;
      strt_glitch       <= 1'b0;

      if (in_frame_s) begin
        if (edge_cnt_r == first_edge_s) smp_r[0] <= rx_in;
        if (edge_cnt_r == mid_edge_s)   smp_r[1] <= rx_in;
        if (edge_cnt_r == third_edge_s) smp_r[2] <= rx_in;
        if (edge_cnt_r == vote_edge_s)  sampled_data <= maj3(smp_r);
        edge_cnt_r <= bit_end_s ? 6'd0 : edge_cnt_r + 6'd1;
      end

      case (state_r)
        IDLE: begin
          edge_cnt_r <= 6'd0;
          if (!rx_in) begin
            // The detection cycle itself is edge 0 of the start bit.
            presc_r    <= prescale;
            par_en_r   <= par_en;
            par_typ_r  <= par_typ;
            par_err_r  <= 1'b0;
            edge_cnt_r <= 6'd1;
            state_r    <= START;
          end
        end
        START: begin
          if (bit_end_s) begin
            if (sampled_data) begin
              strt_glitch <= 1'b1;
              state_r     <= IDLE;
            end else begin
              bit_cnt_r <= 3'd0;
              state_r   <= DATA;
            end
          end
        end
        DATA: begin
          if (bit_end_s) begin
            shift_r[bit_cnt_r] <= sampled_data;
            if (bit_cnt_r == 3'd7) begin
              state_r <= par_en_r ? PARITY : STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
        end
        PARITY: begin
          if (bit_end_s) begin
            par_err_r <= (sampled_data != exp_parity(shift_r, par_typ_r));
            state_r   <= STOP;
          end
        end
        STOP: begin
          if (bit_end_s) begin
            stop_check_enable <= 1'b1;
            state_r           <= DONE;
          end
        end
        DONE: begin
          edge_cnt_r <= 6'd0;
          if (stop_error) stp_error <= 1'b1;
          if (par_err_r)  par_error <= 1'b1;
          if (!stop_error && !par_err_r) begin
            p_data     <= shift_r;
            data_valid <= 1'b1;
          end
          state_r <= IDLE;
        end
        default: begin
          edge_cnt_r <= 6'd0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed table, hand sequences and
// randomized frames checked against a frame-level reference model.
module tb_uart_rx_frame_ctrl;

  logic       clk;
  logic       asy_reset;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic       stop_error;
  logic       sampled_data;
  logic       stop_check_enable;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_error;
  logic       stp_error;
  logic       strt_glitch;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_pdata = 8'h00;

  uart_rx_frame_ctrl dut (
    .clk_based_on_prescale (clk),
    .asy_reset             (asy_reset),
    .rx_in                 (rx_in),
    .prescale              (prescale),
    .par_en                (par_en),
    .par_typ               (par_typ),
    .stop_error            (stop_error),
    .sampled_data          (sampled_data),
    .stop_check_enable     (stop_check_enable),
    .p_data                (p_data),
    .data_valid            (data_valid),
    .par_error             (par_error),
    .stp_error             (stp_error),
    .strt_glitch           (strt_glitch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream stop checker: registered flag of a low stop bit.
  always @(posedge clk or posedge asy_reset) begin
    if (asy_reset) stop_error <= 1'b0;
    else           stop_error <= ~sampled_data;
  end

  typedef struct {
    int         p;
    bit         pe;
    bit         pt;
    logic [7:0] data;
    bit         par_bit;
    bit         stop_bit;
    bit         exp_dv;
    bit         exp_perr;
    bit         exp_serr;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one frame starting at the current negedge and checks every output.
  task automatic run_frame(input int p, input bit pe, input bit pt, input logic [7:0] data,
                           input bit par_bit, input bit stop_bit, input logic [15:0] gmask,
                           input bit exp_dv, input bit exp_perr, input bit exp_serr,
                           input string tag);
    bit bits[$];
    int n, b, o, nb;
    int en_cnt = 0, en_cyc = -1, dv_cnt = 0, dv_cyc = -1, pe_cnt = 0, pe_cyc = -1;
    int se_cnt = 0, se_cyc = -1, sg_cnt = 0, smp_bad = 0;
    logic [7:0] dv_data = 8'h00;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (pe) bits.push_back(par_bit);
    bits.push_back(stop_bit);
    n = bits.size();
    prescale = 6'(p);
    par_en   = pe;
    par_typ  = pt;
    rx_in    = 1'b0;
    for (int rel = 0; rel <= n * p; rel++) begin
      @(negedge clk);
      if (stop_check_enable) begin en_cnt++; en_cyc = rel; end
      if (data_valid) begin dv_cnt++; dv_cyc = rel; dv_data = p_data; end
      if (par_error) begin pe_cnt++; pe_cyc = rel; end
      if (stp_error) begin se_cnt++; se_cyc = rel; end
      if (strt_glitch) sg_cnt++;
      if (rel < n * p) begin
        b = rel / p;
        o = rel % p;
        if (o >= p / 2 + 2 && sampled_data !== bits[b]) smp_bad++;
      end
      if (rel == 0) begin
        prescale = 6'($urandom);
        par_en   = 1'($urandom);
        par_typ  = 1'($urandom);
      end
      nb = rel + 1;
      if (nb < n * p) begin
        b = nb / p;
        o = nb % p;
        rx_in = bits[b] ^ (gmask[b] && (o == p / 2));
      end else begin
        rx_in = 1'b1;
      end
    end
    if (exp_dv) exp_pdata = data;
    check({tag, " enable_count"}, en_cnt, 1);
    check({tag, " enable_cycle"}, en_cyc, n * p - 1);
    check({tag, " valid_count"}, dv_cnt, int'(exp_dv));
    check({tag, " parity_err_count"}, pe_cnt, int'(exp_perr));
    check({tag, " stop_err_count"}, se_cnt, int'(exp_serr));
    check({tag, " glitch_count"}, sg_cnt, 0);
    check({tag, " sample_errors"}, smp_bad, 0);
    check({tag, " p_data_after"}, int'(p_data), int'(exp_pdata));
    if (exp_dv) begin
      check({tag, " valid_cycle"}, dv_cyc, n * p);
      check({tag, " valid_data"}, int'(dv_data), int'(data));
    end
    if (exp_perr) check({tag, " parity_err_cycle"}, pe_cyc, n * p);
    if (exp_serr) check({tag, " stop_err_cycle"}, se_cyc, n * p);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " sampled_data"}, int'(sampled_data), 0);
    check({tag, " stop_check_enable"}, int'(stop_check_enable), 0);
    check({tag, " p_data"}, int'(p_data), 0);
    check({tag, " data_valid"}, int'(data_valid), 0);
    check({tag, " par_error"}, int'(par_error), 0);
    check({tag, " stp_error"}, int'(stp_error), 0);
    check({tag, " strt_glitch"}, int'(strt_glitch), 0);
  endtask

  vec_t vecs[6];

  initial begin
    int sg_cnt, sg_cyc, en_cnt, dv_cnt;
    bit fbits[10];

    vecs[0] = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8,  1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    asy_reset = 1'b1;
    rx_in     = 1'b1;
    prescale  = 6'd8;
    par_en    = 1'b0;
    par_typ   = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    asy_reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].p, vecs[i].pe, vecs[i].pt, vecs[i].data, vecs[i].par_bit,
                vecs[i].stop_bit, 16'h0000, vecs[i].exp_dv, vecs[i].exp_perr,
                vecs[i].exp_serr, $sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
    end

    // Start glitch: line low for two cycles only.
    sg_cnt = 0; sg_cyc = -1; en_cnt = 0; dv_cnt = 0;
    prescale = 6'd8;
    rx_in    = 1'b0;
    @(negedge clk);
    for (int rel = 1; rel <= 15; rel++) begin
      @(negedge clk);
      if (rel == 1) rx_in = 1'b1;
      if (strt_glitch) begin sg_cnt++; sg_cyc = rel; end
      if (stop_check_enable) en_cnt++;
      if (data_valid) dv_cnt++;
    end
    check("glitch count", sg_cnt, 1);
    check("glitch cycle", sg_cyc, 7);
    check("glitch no enable", en_cnt, 0);
    check("glitch no valid", dv_cnt, 0);
    run_frame(8, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, "post_glitch");
    repeat (2) @(negedge clk);

    // Reset during data bit 3 (wire bit 4) of 0x0F while sampled_data is high.
    fbits = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    prescale = 6'd8;
    par_en   = 1'b0;
    rx_in    = 1'b0;
    for (int rel = 0; rel < 39; rel++) begin
      @(negedge clk);
      rx_in = fbits[(rel + 1) / 8];
    end
    check("pre_reset sampled_data", int'(sampled_data), 1);
    #2 asy_reset = 1'b1;
    #1 check_all_zero("mid_reset");
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    asy_reset = 1'b0;
    exp_pdata = 8'h00;
    @(negedge clk);
    run_frame(32, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, "b2b_first");
    run_frame(32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, "b2b_second");

    // Randomized frames against the frame-level reference model.
    for (int k = 0; k < 12; k++) begin
      int         p;
      bit         pe, pt, pbit, sbit, par_ok;
      logic [7:0] d;
      logic [15:0] gm;
      case ($urandom_range(2))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      pe   = 1'($urandom);
      pt   = 1'($urandom);
      d    = 8'($urandom);
      gm   = 16'($urandom) & 16'($urandom);
      pbit = (^d) ^ pt;
      if ($urandom_range(3) == 0) pbit = ~pbit;
      sbit = ($urandom_range(3) != 0);
      par_ok = !pe || (pbit == ((^d) ^ pt));
      run_frame(p, pe, pt, d, pbit, sbit, gm, par_ok && sbit, !par_ok, !sbit,
                $sformatf("rand%0d", k));
      repeat ($urandom_range(3)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
